// File: rtl/dma_tx.sv
// dma_tx -- DMA transmit engine.
//
// On a CPU Start request the engine arbitrates for the system bus, reads
// NUM_BYTES consecutive bytes from RAM starting at TX_BASE_ADDR, and hands
// each byte to the serial transmitter with a Valid_D/TX_Ready handshake.
// After the last byte is accepted it pulses Dma_End for one cycle.
//
// Parameters:
//   NUM_BYTES     bytes per transfer (1..255)
//   TX_BASE_ADDR  RAM address of the first byte; addresses wrap mod 256
//
// Ports:
//   Clk, Rst_n            clock (rising edge), async active-low reset
//   Start                 transfer request, only honoured in IDLE
//   Dma_Ready, Dma_End    idle flag, one-cycle completion pulse
//   Address, Cs, Oe       RAM read strobe (Address is 0 when not reading)
//   Databus               RAM read data, valid one cycle after the strobe
//   Bus_req, Bus_grant    system bus arbitration with the CPU
//   TX_Data, Valid_D      registered byte and valid to the transmitter
//   TX_Ready              transmitter can accept a byte
//
// Build option:
//   DMA_TX_BUS_RELEASE_EN  when defined, the bus is released while each
//                          byte shifts out (WAIT_TX) and re-arbitrated
//                          before the next read.

module dma_tx #(
    parameter int unsigned NUM_BYTES    = 2,
    parameter logic [7:0]  TX_BASE_ADDR = 8'h04
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    output logic       Dma_Ready,
    output logic       Dma_End,
    output logic [7:0] Address,
    input  logic [7:0] Databus,
    output logic       Cs,
    output logic       Oe,
    output logic       Bus_req,
    input  logic       Bus_grant,
    output logic [7:0] TX_Data,
    output logic       Valid_D,
    input  logic       TX_Ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUS_REQUEST,
        S_READ_BYTE,
        S_LATCH_BYTE,
        S_SEND_BYTE,
        S_WAIT_TX,
        S_DMA_END
    } state_e;

    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       seen_low_q, seen_low_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'h00;
            tx_data_q  <= 8'h00;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            seen_low_q <= seen_low_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        seen_low_d = seen_low_q;
        Dma_Ready  = 1'b0;
        Dma_End    = 1'b0;
        Address    = 8'h00;
        Cs         = 1'b0;
        Oe         = 1'b0;
        Bus_req    = 1'b0;
        Valid_D    = 1'b0;

        case (state_q)
            S_IDLE: begin
                Dma_Ready = 1'b1;
                if (Start) begin
                    // Request is raised combinationally in the Start cycle;
                    // qualified with Rst_n so reset forces it low even with
                    // Start held high.
                    Bus_req = Rst_n;
                    cnt_d   = 8'h00;
                    state_d = S_BUS_REQUEST;
                end
            end
            S_BUS_REQUEST: begin
                Bus_req = 1'b1;
                if (Bus_grant) state_d = S_READ_BYTE;
            end
            S_READ_BYTE: begin
                Bus_req = 1'b1;
                Cs      = Bus_grant;
                Oe      = Bus_grant;
                Address = TX_BASE_ADDR + cnt_q;
                if (Bus_grant) state_d = S_LATCH_BYTE;
            end
            S_LATCH_BYTE: begin
                // RAM data arrives exactly one cycle after the strobe.
                Bus_req   = 1'b1;
                tx_data_d = Databus;
                state_d   = S_SEND_BYTE;
            end
            S_SEND_BYTE: begin
                Bus_req = 1'b1;
                Valid_D = 1'b1;
                if (TX_Ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DMA_END;
                    end else begin
                        cnt_d      = cnt_q + 8'h01;
                        seen_low_d = 1'b0;
                        state_d    = S_WAIT_TX;
                    end
                end
            end
            S_WAIT_TX: begin
`ifdef DMA_TX_BUS_RELEASE_EN
                Bus_req = 1'b0;
`else
                Bus_req = 1'b1;
`endif
                // The transmitter is done with the byte only after TX_Ready
                // has dropped and come back; a high level alone may still be
                // the acceptance cycle.
                if (!TX_Ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    seen_low_d = 1'b0;
`ifdef DMA_TX_BUS_RELEASE_EN
                    state_d = S_BUS_REQUEST;
`else
                    state_d = S_READ_BYTE;
`endif
                end
            end
            S_DMA_END: begin
                Dma_End = 1'b1;
                Bus_req = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign TX_Data = tx_data_q;

endmodule

// File: tb/tb_dma_tx.sv
module tb_dma_tx;

    localparam int         NB   = 2;
    localparam logic [7:0] BASE = 8'h04;
`ifdef DMA_TX_BUS_RELEASE_EN
    localparam logic WB = 1'b0;
`else
    localparam logic WB = 1'b1;
`endif

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic Start = 1'b0;
    logic Dma_Ready, Dma_End, Cs, Oe, Bus_req, Valid_D;
    logic [7:0] Address, TX_Data;
    logic Bus_grant, TX_Ready;
    logic [7:0] Databus;

    // manual drive vs. behavioural peripheral models
    logic model_en = 1'b0;
    logic man_grant = 1'b0, man_txr = 1'b1;
    logic [7:0] man_db = 8'h00;
    logic m_grant = 1'b0, m_txr = 1'b1;
    logic [7:0] m_db = 8'h00;
    int busy = 0;
    logic [7:0] ram [256];

    assign Bus_grant = model_en ? m_grant : man_grant;
    assign TX_Ready  = model_en ? m_txr   : man_txr;
    assign Databus   = model_en ? m_db    : man_db;

    always #5 Clk = ~Clk;

    dma_tx #(.NUM_BYTES(NB), .TX_BASE_ADDR(BASE)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Dma_Ready(Dma_Ready),
        .Dma_End(Dma_End), .Address(Address), .Databus(Databus), .Cs(Cs),
        .Oe(Oe), .Bus_req(Bus_req), .Bus_grant(Bus_grant), .TX_Data(TX_Data),
        .Valid_D(Valid_D), .TX_Ready(TX_Ready)
    );

    // second instance: address wrap with 3 bytes from 8'hFF
    logic Start2 = 1'b0;
    logic Dma_Ready2, Dma_End2, Cs2, Oe2, Bus_req2, Valid_D2;
    logic [7:0] Address2, TX_Data2;
    logic Bus_grant2 = 1'b1;
    logic [7:0] Databus2 = 8'h00;
    logic TX_Ready2 = 1'b1;

    dma_tx #(.NUM_BYTES(3), .TX_BASE_ADDR(8'hFF)) dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start2), .Dma_Ready(Dma_Ready2),
        .Dma_End(Dma_End2), .Address(Address2), .Databus(Databus2), .Cs(Cs2),
        .Oe(Oe2), .Bus_req(Bus_req2), .Bus_grant(Bus_grant2), .TX_Data(TX_Data2),
        .Valid_D(Valid_D2), .TX_Ready(TX_Ready2)
    );

    int n_vec = 0, n_miss = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, Dma_Ready, Bus_req, Cs, Oe, Valid_D, Dma_End, Address, TX_Data};
    endfunction

    // ---------------- peripheral models ----------------
    always @(posedge Clk) begin
        m_grant <= Bus_req && ($urandom_range(0, 3) != 0);
        if (Cs && Oe) m_db <= ram[Address];
        if (m_txr && Valid_D) begin
            m_txr <= 1'b0;
            busy  <= $urandom_range(0, 5);
        end else if (!m_txr) begin
            if (busy == 0) m_txr <= 1'b1;
            else busy <= busy - 1;
        end
        TX_Ready2 <= ~(Valid_D2 & TX_Ready2);
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int done = 0;
    logic [7:0] addr2_q[$];
    int end2_cnt = 0;

    always begin
        @(negedge Clk);
        #1;
        if (Rst_n) begin
            if (Cs2) addr2_q.push_back(Address2);
            if (Dma_End2) end2_cnt++;
        end
        if (model_en && Rst_n) begin
            if (Start && Dma_Ready)
                for (int i = 0; i < NB; i++) exp_q.push_back(ram[8'(BASE + 8'(i))]);
            if (Cs)
                check("rd_addr", {Oe, Bus_grant, Address}, {1'b1, 1'b1, 8'(BASE + 8'(done))});
            if (Valid_D && TX_Ready) begin
                check("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("tx_byte", {Bus_req, TX_Data}, {1'b1, exp_q.pop_front()});
                done++;
            end
            if (Dma_End) begin
                check("end_count", done, NB);
                done = 0;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic start, grant, txr;
        logic [7:0] db;
        logic ready, breq, cs;
        logic [7:0] addr;
        logic valid;
        logic [7:0] txd;
        logic dend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic gr, logic tr, logic [7:0] db,
                                logic rd, logic bq, logic cs, logic [7:0] ad,
                                logic vd, logic [7:0] td, logic de);
        vec_t v;
        v.start = st; v.grant = gr; v.txr = tr; v.db = db;
        v.ready = rd; v.breq = bq; v.cs = cs; v.addr = ad;
        v.valid = vd; v.txd = td; v.dend = de;
        return v;
    endfunction

    task automatic run_to_end(input string nm);
        int ends = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge Clk);
            man_grant = 1'b1;
            man_txr = ~man_txr;
            #1;
            if (Dma_End) ends++;
            if (ends > 0 && Dma_Ready) break;
        end
        check(nm, ends, 1);
    endtask

    task automatic reset_dut();
        @(negedge Clk);
        Rst_n = 1'b0;
        Start = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic to_send(input logic [7:0] db);
        // Start, BUS_REQUEST, READ_BYTE, LATCH_BYTE with grant already high
        man_grant = 1'b1; man_txr = 1'b0; man_db = db;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk); #1;
        check("latency_latch", Valid_D, 0);
    endtask

    logic [7:0] wrap_exp [3];

    initial begin
        // reset state
        #12;
        check("reset", outs(), 32'h0020_0000);
        @(negedge Clk);
        Rst_n = 1'b1;

        // basic transfer, cycle by cycle (Start pulse in WAIT_TX is ignored)
        tbl.push_back(mk(1,0,1,8'h00, 1,1,0,8'h00, 0,8'h00,0));
        tbl.push_back(mk(0,1,1,8'h00, 0,1,0,8'h00, 0,8'h00,0));
        tbl.push_back(mk(0,1,1,8'h00, 0,1,1,8'h04, 0,8'h00,0));
        tbl.push_back(mk(0,1,1,8'hA5, 0,1,0,8'h00, 0,8'h00,0));
        tbl.push_back(mk(0,1,0,8'h00, 0,1,0,8'h00, 1,8'hA5,0));
        tbl.push_back(mk(0,1,1,8'h00, 0,1,0,8'h00, 1,8'hA5,0));
        tbl.push_back(mk(1,1,0,8'h00, 0,WB,0,8'h00, 0,8'hA5,0));
        tbl.push_back(mk(0,1,1,8'h00, 0,WB,0,8'h00, 0,8'hA5,0));
`ifdef DMA_TX_BUS_RELEASE_EN
        tbl.push_back(mk(0,1,1,8'h00, 0,1,0,8'h00, 0,8'hA5,0));
`endif
        tbl.push_back(mk(0,0,1,8'h00, 0,1,0,8'h05, 0,8'hA5,0));
        tbl.push_back(mk(0,1,1,8'h00, 0,1,1,8'h05, 0,8'hA5,0));
        tbl.push_back(mk(0,1,1,8'h3C, 0,1,0,8'h00, 0,8'hA5,0));
        tbl.push_back(mk(0,1,1,8'h00, 0,1,0,8'h00, 1,8'h3C,0));
        tbl.push_back(mk(0,1,1,8'h00, 0,1,0,8'h00, 0,8'h3C,1));
        tbl.push_back(mk(0,0,1,8'h00, 1,0,0,8'h00, 0,8'h3C,0));
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clk);
            Start = tbl[i].start; man_grant = tbl[i].grant;
            man_txr = tbl[i].txr; man_db = tbl[i].db;
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {10'd0, tbl[i].ready, tbl[i].breq, tbl[i].cs, tbl[i].cs,
                   tbl[i].valid, tbl[i].dend, tbl[i].addr, tbl[i].txd});
        end

        // transmitter backpressure: 20 cycles held in SEND_BYTE
        reset_dut();
        to_send(8'hA5);
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk); #1;
            check($sformatf("bp_hold%0d", c), {Valid_D, TX_Data}, {1'b1, 8'hA5});
        end
        @(negedge Clk); man_txr = 1'b1; #1;
        check("bp_xfer", {Valid_D, TX_Data}, {1'b1, 8'hA5});
        @(negedge Clk); man_txr = 1'b0; #1;
        check("bp_after", Valid_D, 0);
        run_to_end("bp_end");

        // grant withheld 10 cycles
        reset_dut();
        man_grant = 1'b0; man_txr = 1'b1;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("stall%0d", c), {Cs, Oe, Valid_D, Bus_req}, 4'b0001);
            @(negedge Clk);
        end
        run_to_end("stall_end");

        // reset in SEND_BYTE
        reset_dut();
        to_send(8'h5A);
        @(negedge Clk); #1;
        check("pre_rst_valid", Valid_D, 1);
        Rst_n = 1'b0;
        #1;
        check("rst_mid", outs(), 32'h0020_0000);
        @(negedge Clk); Rst_n = 1'b1;
        begin
            int ends = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge Clk); #1;
                if (Dma_End) ends++;
            end
            check("rst_no_end", {Dma_Ready, 8'(ends)}, {1'b1, 8'd0});
        end

        // randomized traffic against the scoreboard; dut2 runs its wrap
        for (int a = 0; a < 256; a++) ram[a] = 8'($urandom);
        model_en = 1'b1;
        reset_dut();
        @(negedge Clk); Start2 = 1'b1;
        @(negedge Clk); Start2 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            Start = ($urandom_range(0, 9) < 3);
        end
        @(negedge Clk); Start = 1'b0;
        for (int c = 0; c < 500 && !(Dma_Ready && exp_q.size() == 0); c++) @(negedge Clk);
        #2;
        check("drain", {Dma_Ready, exp_q.size() == 0}, 2'b11);

        wrap_exp[0] = 8'hFF; wrap_exp[1] = 8'h00; wrap_exp[2] = 8'h01;
        check("wrap_n", addr2_q.size(), 3);
        if (addr2_q.size() == 3)
            for (int i = 0; i < 3; i++) check($sformatf("wrap_addr%0d", i), addr2_q[i], wrap_exp[i]);
        check("wrap_end", end2_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dma_tx.md
Name: dma_tx

Overview:
- DMA transmit engine: on CPU request, fetches NUM_BYTES consecutive bytes from the RAM TX buffer and hands each byte to the serial transmitter.
- Sits between RAM, CPU bus arbitration and the RS232 TX.
- Counterpart of the DMA receive path.
- Arbitrates for the system bus with Bus_req/Bus_grant and pulses Dma_End when the last byte has been accepted by the transmitter.

Parameters:
- NUM_BYTES, 2, number of bytes per transfer (1..255).
- TX_BASE_ADDR, 8'h04, RAM address of the first byte (MSB first).

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  CPU transfer request, sampled in IDLE only.
- Dma_Ready  output  1  high while the FSM is in IDLE.
- Dma_End  output  1  one-cycle pulse, transfer complete.
- Address  output  8  RAM address, '0 when not reading.
- Databus  input  8  RAM read data, valid one cycle after a read strobe.
- Cs  output  1  RAM chip select.
- Oe  output  1  RAM output enable.
- Bus_req  output  1  system bus request to the CPU.
- Bus_grant  input  1  bus granted by the CPU.
- TX_Data  output  8  byte to the serial transmitter (registered).
- Valid_D  output  1  TX_Data valid.
- TX_Ready  input  1  transmitter idle and able to accept.

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE, byte counter=0, TX_Data=8'h00.
  - Dma_Ready=1; every other output is 0.
- States: IDLE, BUS_REQUEST, READ_BYTE, LATCH_BYTE, SEND_BYTE, WAIT_TX, DMA_END.
- IDLE: Dma_Ready=1. Start=1 -> Bus_req=1 in the same cycle, clear counter, go to BUS_REQUEST.
- BUS_REQUEST: Bus_req=1. Go to READ_BYTE when Bus_grant=1.
- READ_BYTE:
  - Bus_req=1; Cs=Oe=Bus_grant; Address=TX_BASE_ADDR+counter (8-bit, wraps mod 256).
  - Bus_grant=1 -> LATCH_BYTE. Otherwise stall here with Cs=Oe=0.
- LATCH_BYTE: Bus_req=1. TX_Data<=Databus on this edge, then SEND_BYTE. RAM read latency is exactly 1 cycle.
- SEND_BYTE:
  - Bus_req=1, Valid_D=1; TX_Data held stable.
  - Transfer occurs in the cycle where Valid_D=1 and TX_Ready=1.
  - On transfer: if counter==NUM_BYTES-1 -> DMA_END; else counter++ and go to WAIT_TX.
- WAIT_TX: Bus_req=1. Wait for TX_Ready=0 then back to 1 (the transmitter has consumed the byte), then READ_BYTE. A 1-bit flag records that TX_Ready has been seen low.
- DMA_END: Dma_End=1 and Bus_req=1 for one cycle, then IDLE. Bus_req drops in the first IDLE cycle.
- Start while not in IDLE is ignored; it is not queued.
- Start held high across DMA_END begins a new transfer in the first IDLE cycle.
- Reset asserted mid-transfer: immediate return to IDLE, no Dma_End, Bus_req released asynchronously.
- Minimum latency, Start to first Valid_D with Bus_grant already high: 4 cycles (IDLE, BUS_REQUEST, READ_BYTE, LATCH_BYTE).
- Outputs not named in a state are 0.

Optional Feature:
- Macro: DMA_TX_BUS_RELEASE_EN.
- Defined:
  - In WAIT_TX, Bus_req=0, giving the bus back to the CPU while the serial byte shifts out.
  - On leaving WAIT_TX, go to BUS_REQUEST (re-arbitrate) instead of READ_BYTE.
- Undefined: Bus_req is held from Start to DMA_END inclusive.

Test Plan:
- Basic transfer:
  - Stimulus: RAM[04]=8'hA5, RAM[05]=8'h3C; Start pulse; Bus_grant returned one cycle after Bus_req; TX_Ready toggled by a TX model.
  - Response: TX_Data sequence A5 then 3C; Address 04 then 05; exactly one Dma_End pulse; Bus_req low in the cycle after Dma_End.
- Grant stall: Bus_grant withheld 10 cycles -> Cs=Oe=0 and no Valid_D throughout; the transfer completes normally once grant arrives.
- Transmitter backpressure:
  - Stimulus: TX_Ready held low 20 cycles during SEND_BYTE.
  - Response: Valid_D and TX_Data (e.g. A5) stable all 20 cycles; transfer on the first cycle TX_Ready=1.
- Start while busy: second Start pulse during WAIT_TX -> ignored, only 2 bytes sent; Start asserted after Dma_End -> a new transfer begins.
- Reset and wrap:
  - Rst_n low during SEND_BYTE: all outputs 0 immediately, Dma_Ready=1, no Dma_End.
  - Separately, NUM_BYTES=3, TX_BASE_ADDR=8'hFF: Address sequence FF, 00, 01.
- With DMA_TX_BUS_RELEASE_EN: Bus_req=0 throughout each WAIT_TX; FSM passes through BUS_REQUEST before each subsequent byte read.
